// File: rtl/bicubic_phase_gen.sv
// Horizontal DDA phase generator for the bicubic weight stage: emits the Q1.8 blend
// fraction and four clamped source-column taps per destination pixel, one per accept.
module bicubic_phase_gen #(
  parameter int CW     = 12,
  parameter int STEP_W = 16,
  parameter int ACC_W  = 22
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_start,
  input  logic [CW-1:0]     cfg_src_w,
  input  logic [CW-1:0]     cfg_dst_w,
  input  logic [CW-1:0]     cfg_dst_h,
  input  logic [STEP_W-1:0] cfg_step,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [8:0]        x_blend,
  output logic [CW-1:0]     tap0,
  output logic [CW-1:0]     tap1,
  output logic [CW-1:0]     tap2,
  output logic [CW-1:0]     tap3,
  output logic              out_last_pix,
  output logic              out_last_row,
  output logic              frame_done
);

  // state | meaning
  // IDLE  | waiting for cfg_start
  // RUN   | streaming outputs, advancing on each accept
  // DONE  | one cycle, frame_done pulsed
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int XW = CW + 2;

  state_t                   state;
  logic [CW-1:0]            src_w, dst_w, dst_h, col, row;
  logic [STEP_W-1:0]        step;
  logic signed [ACC_W-1:0]  acc;

  logic [CW-1:0]            src_w_n, dst_w_n, dst_h_n, col_n, row_n;
  logic signed [ACC_W-1:0]  acc_n, xi_full;
  logic signed [XW-1:0]     xi, hi, tv;
  logic [CW-1:0]            tap_n [4];
  logic                     load, accept, last_col, last_row, final_px, upd;
  logic                     last_pix_n, last_row_n;

  function automatic logic signed [ACC_W-1:0] init_acc(input logic [STEP_W-1:0] s);
    return $signed({{(ACC_W-STEP_W+1){1'b0}}, s[STEP_W-1:1]}) - $signed(ACC_W'(128));
  endfunction

  assign load     = (state == IDLE) && cfg_start;
  assign accept   = (state == RUN) && out_valid && out_ready;
  assign last_col = (col == dst_w - 1'b1);
  assign last_row = (row == dst_h - 1'b1);
  assign final_px = last_col && last_row;
  assign upd      = load || (accept && !final_px);

  always_comb begin
    src_w_n = src_w;
    dst_w_n = dst_w;
    dst_h_n = dst_h;
    acc_n   = acc;
    col_n   = col;
    row_n   = row;
    if (load) begin
      src_w_n = cfg_src_w;
      dst_w_n = cfg_dst_w;
      dst_h_n = cfg_dst_h;
      acc_n   = init_acc(cfg_step);
      col_n   = '0;
      row_n   = '0;
    end else if (accept && !final_px) begin
      if (last_col) begin
        acc_n = init_acc(step);
        col_n = '0;
        row_n = row + 1'b1;
      end else begin
        acc_n = acc + $signed({{(ACC_W-STEP_W){1'b0}}, step});
        col_n = col + 1'b1;
      end
    end
  end

  // Taps are decoded from the next accumulator so the outputs can be registered.
  always_comb begin
    xi_full = acc_n >>> 8;
    xi      = xi_full[XW-1:0];
    hi      = $signed({2'b00, src_w_n}) - $signed(XW'(1));
    tv      = '0;
    for (int k = 0; k < 4; k++) begin
      tv = xi + $signed(XW'(k)) - $signed(XW'(1));
      if (tv < 0)
        tap_n[k] = '0;
      else if (tv > hi)
        tap_n[k] = hi[CW-1:0];
      else
        tap_n[k] = tv[CW-1:0];
    end
  end

  assign last_pix_n = (col_n == dst_w_n - 1'b1);
  assign last_row_n = (row_n == dst_h_n - 1'b1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      src_w        <= '0;
      dst_w        <= '0;
      dst_h        <= '0;
      step         <= '0;
      acc          <= '0;
      col          <= '0;
      row          <= '0;
      busy         <= 1'b0;
      out_valid    <= 1'b0;
      x_blend      <= '0;
      tap0         <= '0;
      tap1         <= '0;
      tap2         <= '0;
      tap3         <= '0;
      out_last_pix <= 1'b0;
      out_last_row <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      if (upd) begin
        acc          <= acc_n;
        col          <= col_n;
        row          <= row_n;
        x_blend      <= {1'b0, acc_n[7:0]};
        tap0         <= tap_n[0];
        tap1         <= tap_n[1];
        tap2         <= tap_n[2];
        tap3         <= tap_n[3];
        out_last_pix <= last_pix_n;
        out_last_row <= last_row_n;
      end
      case (state)
        IDLE: begin
          frame_done <= 1'b0;
          if (cfg_start) begin
            src_w     <= cfg_src_w;
            dst_w     <= cfg_dst_w;
            dst_h     <= cfg_dst_h;
            step      <= cfg_step;
            busy      <= 1'b1;
            out_valid <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          if (accept && final_px) begin
            out_valid  <= 1'b0;
            frame_done <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          frame_done <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bicubic_phase_gen.sv
// Directed bench for bicubic_phase_gen: hand-computed blend/tap vectors, backpressure,
// multi-row, ignored restart and mid-frame reset.
module tb_bicubic_phase_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_start;
  logic [11:0] cfg_src_w, cfg_dst_w, cfg_dst_h;
  logic [15:0] cfg_step;
  logic        busy, out_valid, out_ready;
  logic [8:0]  x_blend;
  logic [11:0] tap0, tap1, tap2, tap3;
  logic        out_last_pix, out_last_row, frame_done;

  int n_chk  = 0;
  int n_pass = 0;

  bicubic_phase_gen dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start),
    .cfg_src_w(cfg_src_w), .cfg_dst_w(cfg_dst_w), .cfg_dst_h(cfg_dst_h),
    .cfg_step(cfg_step), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .x_blend(x_blend), .tap0(tap0), .tap1(tap1), .tap2(tap2), .tap3(tap3),
    .out_last_pix(out_last_pix), .out_last_row(out_last_row), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int src, input int dst, input int h, input int stp);
    cfg_src_w = 12'(src);
    cfg_dst_w = 12'(dst);
    cfg_dst_h = 12'(h);
    cfg_step  = 16'(stp);
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
  endtask

  task automatic px(input string tag, input int bl, input int t0, input int t1,
                    input int t2, input int t3, input int lp, input int lr);
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".blend"}, 32'(x_blend), 32'(bl));
    check({tag, ".taps"}, {tap0[7:0], tap1[7:0], tap2[7:0], tap3[7:0]},
          {8'(t0), 8'(t1), 8'(t2), 8'(t3)});
    check({tag, ".lastpix"}, 32'(out_last_pix), 32'(lp));
    check({tag, ".lastrow"}, 32'(out_last_row), 32'(lr));
  endtask

  task automatic expect_done(input string tag);
    check({tag, ".done"}, 32'(frame_done), 32'd1);
    check({tag, ".valid_off"}, 32'(out_valid), 32'd0);
    step();
    check({tag, ".done_pulse"}, 32'(frame_done), 32'd0);
    check({tag, ".idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1; cfg_start = 1'b0; out_ready = 1'b1;
    cfg_src_w = '0; cfg_dst_w = '0; cfg_dst_h = '0; cfg_step = '0;
    step(); step();
    check("rst.busy", 32'(busy), 0);
    check("rst.valid", 32'(out_valid), 0);
    check("rst.outs", {x_blend, tap0, tap1[7:0], out_last_pix, out_last_row, frame_done},
          32'd0);
    rst = 1'b0;
    step();

    // 1:1 scaling
    start(4, 4, 1, 256);
    check("t1.busy", 32'(busy), 1);
    px("t1c0", 0, 0, 0, 1, 2, 0, 1); step();
    px("t1c1", 0, 0, 1, 2, 3, 0, 1); step();
    px("t1c2", 0, 1, 2, 3, 3, 0, 1); step();
    px("t1c3", 0, 2, 3, 3, 3, 1, 1); step();
    expect_done("t1");

    // backpressure at col2
    start(4, 4, 1, 256);
    step(); step();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      px("t3hold", 0, 1, 2, 3, 3, 0, 1);
    end
    out_ready = 1'b1;
    step();
    px("t3c3", 0, 2, 3, 3, 3, 1, 1); step();
    expect_done("t3");

    // 2x upscale: acc = -64 + 128*col
    start(4, 8, 1, 128);
    px("t2c0", 192, 0, 0, 0, 1, 0, 1); step();
    px("t2c1", 64, 0, 0, 1, 2, 0, 1);
    for (int i = 0; i < 6; i++) step();
    px("t2c7", 64, 2, 3, 3, 3, 1, 1); step();
    expect_done("t2");

    // two rows share the phase sequence
    start(4, 3, 2, 256);
    for (int r = 0; r < 2; r++) begin
      px("t4c0", 0, 0, 0, 1, 2, 0, r); step();
      px("t4c1", 0, 0, 1, 2, 3, 0, r); step();
      px("t4c2", 0, 1, 2, 3, 3, 1, r); step();
    end
    expect_done("t4");

    // mid-frame start ignored; start right after frame_done accepted
    start(4, 3, 1, 256);
    px("t5c0", 0, 0, 0, 1, 2, 0, 1); step();
    cfg_src_w = 12'd8; cfg_dst_w = 12'd5; cfg_dst_h = 12'd1; cfg_step = 16'd128;
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    px("t5c2", 0, 1, 2, 3, 3, 1, 1); step();
    expect_done("t5");
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    px("t5new0", 192, 0, 0, 0, 1, 0, 1); step();
    px("t5new1", 64, 0, 0, 1, 2, 0, 1);

    // reset at row0 col1
    rst = 1'b1;
    step();
    check("t6.busy", 32'(busy), 0);
    check("t6.valid", 32'(out_valid), 0);
    check("t6.done", 32'(frame_done), 0);
    check("t6.outs", {x_blend, tap0, tap1[7:0], out_last_pix, out_last_row, 1'b0}, 32'd0);
    check("t6.taps23", {tap2, tap3}, 32'd0);
    rst = 1'b0;
    step();
    check("t6.nodone", 32'(frame_done), 0);
    start(4, 4, 1, 256);
    px("t6c0", 0, 0, 0, 1, 2, 0, 1);
    step(); step(); step();
    px("t6c3", 0, 2, 3, 3, 3, 1, 1); step();
    expect_done("t6");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
